// File: rtl/reg_file_sbus_master_pkg.sv
// Shared types and constants for the serial register-file bus master.
// The register file, the master and the bench all use the same address map.
package reg_file_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam int CMD_CYCLES   = 1;
  localparam int ADDR_BITS    = 8;
  localparam int DATA_BITS    = 8;
  // One IDLE arbitration cycle and one DONE/ACK cycle frame the serial part.
  localparam int FRAME_CYCLES = CMD_CYCLES + ADDR_BITS + DATA_BITS + 2;

  localparam int N_REGS = 5;
  localparam logic [N_REGS-1:0][7:0] REG_ADDR_MAP = {8'h55, 8'h06, 8'hA1, 8'h78, 8'h34};
  localparam logic [7:0] RO_ADDR        = 8'h55;
  localparam logic [7:0] RO_RESET_VALUE = 8'h33;

  // Map index of a register address, or -1 when the address is unmapped.
  function automatic int reg_index(input logic [7:0] addr);
    int ix;
    ix = -1;
    for (int i = 0; i < N_REGS; i++) begin
      if (REG_ADDR_MAP[i] == addr) ix = i;
    end
    return ix;
  endfunction

endpackage

// File: rtl/reg_file_sbus_master_if.sv
// Requester bus and single-wire register-file bus of the serial master.
// The master modport is the bus master; the slave modport is requesters plus register file.
interface reg_file_sbus_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [N_REQ-1:0]            REQ;
  logic [N_REQ-1:0]            REQ_WR;
  logic [N_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
  logic [N_REQ*DATA_WIDTH-1:0] REQ_WDATA;
  logic [N_REQ-1:0]            ACK;
  logic [DATA_WIDTH-1:0]       RDATA;
  logic                        BUSY;
  logic                        RD_EN;
  logic                        WR_EN;
  logic                        DIN;
  logic                        DOUT;

  modport master (
    input  REQ, REQ_WR, REQ_ADDR, REQ_WDATA, DOUT,
    output ACK, RDATA, BUSY, RD_EN, WR_EN, DIN
  );

  modport slave (
    output REQ, REQ_WR, REQ_ADDR, REQ_WDATA, DOUT,
    input  ACK, RDATA, BUSY, RD_EN, WR_EN, DIN
  );
endinterface

// File: rtl/reg_file_sbus_master_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above ptr_i wins,
// wrapping around. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves a latch.
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_sbus_master.sv
// Serial-bus master: arbitrates N_REQ parallel requesters and serialises each granted
// request into the register file's CMD / 8 address / 8 data bit frame.
module reg_file_sbus_master
  import reg_file_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            RSTN,
  reg_file_sbus_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        gnt_idx_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rshift_q;
  logic [3:0]              bit_cnt_q;
  logic [N_REQ-1:0]        ack_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    busy_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic                    din_q;

  logic [N_REQ-1:0]        arb_gnt;
  logic [IDX_W-1:0]        arb_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i     (bus.REQ),
    .ptr_i     (ptr_q),
    .en_i      (state_q == ST_IDLE),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Outputs are registered for the state being entered, so each lands in its own cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      // NOTE: the latched request registers are reset too, so DIN can never carry X.
      gnt_idx_q <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rshift_q  <= '0;
      bit_cnt_q <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      din_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads the pre-edge values.
      ack_q   <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_gnt != '0) begin
            gnt_idx_q <= arb_idx;
            wr_q      <= bus.REQ_WR[arb_idx];
            addr_q    <= bus.REQ_ADDR[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q   <= bus.REQ_WDATA[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            wr_en_q   <= bus.REQ_WR[arb_idx];
            rd_en_q   <= ~bus.REQ_WR[arb_idx];
            busy_q    <= 1'b1;
            din_q     <= 1'b0;
            state_q   <= ST_CMD;
          end
        end
        ST_CMD: begin
          din_q     <= addr_q[ADDR_WIDTH-1];
          addr_q    <= addr_q << 1;
          bit_cnt_q <= 4'(ADDR_WIDTH - 1);
          state_q   <= ST_ADDR;
        end
        ST_ADDR: begin
          if (bit_cnt_q == '0) begin
            // Reads drive zeros on DIN while the register file shifts data out.
            din_q     <= wr_q & wdata_q[DATA_WIDTH-1];
            wdata_q   <= wdata_q << 1;
            bit_cnt_q <= 4'(DATA_WIDTH - 1);
            state_q   <= ST_DATA;
          end else begin
            din_q     <= addr_q[ADDR_WIDTH-1];
            addr_q    <= addr_q << 1;
            bit_cnt_q <= bit_cnt_q - 4'd1;
          end
        end
        ST_DATA: begin
          if (!wr_q) rshift_q <= {rshift_q[DATA_WIDTH-2:0], bus.DOUT};
          if (bit_cnt_q == '0) begin
            din_q            <= 1'b0;
            ack_q[gnt_idx_q] <= 1'b1;
            if (!wr_q) rdata_q <= {rshift_q[DATA_WIDTH-2:0], bus.DOUT};
            state_q          <= ST_DONE;
          end else begin
            din_q     <= wr_q & wdata_q[DATA_WIDTH-1];
            wdata_q   <= wdata_q << 1;
            bit_cnt_q <= bit_cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ACK   = ack_q;
  assign bus.RDATA = rdata_q;
  assign bus.BUSY  = busy_q;
  assign bus.RD_EN = rd_en_q;
  assign bus.WR_EN = wr_en_q;
  assign bus.DIN   = din_q;

endmodule

// File: tb/tb_reg_file_sbus_master.sv
// Bench for reg_file_sbus_master: behavioural serial register file on the slave side,
// an in-order scoreboard of expected ACK/RDATA filled when each request is driven.
module tb_reg_file_sbus_master;
  import reg_file_pkg::*;

  localparam int N_REQ = 2;
  localparam int AW    = 8;
  localparam int DW    = 8;

  typedef struct {
    int         idx;
    logic       wr;
    logic [7:0] rdata;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_sbus_if #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sbus ();

  reg_file_sbus_master #(.N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK  (clk),
    .RSTN (rst_n),
    .bus  (sbus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- serial register file model ----------------
  logic [7:0] rf_mem [N_REGS];
  int         rf_phase;
  int         rf_cnt;
  logic       rf_wr;
  logic [7:0] rf_addr;
  logic [7:0] rf_data;
  logic       rf_dout;
  int         rf_violations = 0;
  logic [7:0] rf_next_addr;
  logic [7:0] rf_rd_val;
  int         rf_wr_ix;

  assign sbus.DOUT = rf_dout;

  always_comb begin
    rf_next_addr = {rf_addr[6:0], sbus.DIN};
    rf_rd_val    = 8'h00;
    rf_wr_ix     = -1;
    for (int i = 0; i < N_REGS; i++) begin
      if (REG_ADDR_MAP[i] == rf_next_addr) rf_rd_val = rf_mem[i];
      if (REG_ADDR_MAP[i] == rf_addr)      rf_wr_ix  = i;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++)
        rf_mem[i] <= (REG_ADDR_MAP[i] == RO_ADDR) ? RO_RESET_VALUE : 8'h00;
      rf_phase <= 0;
      rf_cnt   <= 0;
      rf_wr    <= 1'b0;
      rf_addr  <= 8'h00;
      rf_data  <= 8'h00;
      rf_dout  <= 1'b0;
    end else if (sbus.RD_EN || sbus.WR_EN) begin
      if (rf_phase != 0) rf_violations <= rf_violations + 1;
      rf_phase <= 1;
      rf_cnt   <= 0;
      rf_wr    <= sbus.WR_EN;
      rf_dout  <= 1'b0;
    end else if (rf_phase == 1) begin
      rf_addr <= rf_next_addr;
      if (rf_cnt == 7) begin
        rf_phase <= 2;
        rf_cnt   <= 0;
        if (!rf_wr) begin
          rf_dout <= rf_rd_val[7];
          rf_data <= rf_rd_val << 1;
        end
      end else begin
        rf_cnt <= rf_cnt + 1;
      end
    end else if (rf_phase == 2) begin
      if (rf_wr) begin
        rf_data <= {rf_data[6:0], sbus.DIN};
        if (rf_cnt == 7) begin
          if (rf_wr_ix >= 0 && rf_addr != RO_ADDR) rf_mem[rf_wr_ix] <= {rf_data[6:0], sbus.DIN};
          rf_phase <= 0;
        end else begin
          rf_cnt <= rf_cnt + 1;
        end
      end else if (rf_cnt == 7) begin
        rf_phase <= 0;
        rf_dout  <= 1'b0;
      end else begin
        rf_dout <= rf_data[7];
        rf_data <= rf_data << 1;
        rf_cnt  <= rf_cnt + 1;
      end
    end
  end

  // ---------------- reference contents and scoreboard ----------------
  logic [7:0] ref_mem [N_REGS];
  exp_t       sb [$];
  int         n_checks   = 0;
  int         n_pass     = 0;
  int         exp_ptr    = 0;
  logic [7:0] last_rdata = 8'h00;

  function automatic void ref_reset();
    for (int i = 0; i < N_REGS; i++) ref_mem[i] = (REG_ADDR_MAP[i] == RO_ADDR) ? RO_RESET_VALUE : 8'h00;
  endfunction

  function automatic logic [7:0] ref_read(input logic [7:0] addr);
    int ix;
    ix = reg_index(addr);
    return (ix < 0) ? 8'h00 : ref_mem[ix];
  endfunction

  function automatic void ref_write(input logic [7:0] addr, input logic [7:0] data);
    int ix;
    ix = reg_index(addr);
    if (ix >= 0 && addr != RO_ADDR) ref_mem[ix] = data;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic apply_reset();
    rst_n          = 1'b0;
    sbus.REQ       = '0;
    sbus.REQ_WR    = '0;
    sbus.REQ_ADDR  = '0;
    sbus.REQ_WDATA = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ref_reset();
    sb.delete();
    exp_ptr    = 0;
    last_rdata = 8'h00;
    @(negedge clk);
  endtask

  // Drives one request, pushes its expectation, and records what the bus did.
  task automatic do_txn(input int i, input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        output int ack_rel, output logic [N_REQ-1:0] ack_v, output logic [7:0] rdata,
                        output logic [15:0] din_seq, output int en_rel, output logic [1:0] en_kind);
    exp_t e;
    int   t0;
    int   rel;
    @(negedge clk);
    sbus.REQ_WR[i]              = wr;
    sbus.REQ_ADDR[i*AW +: AW]   = addr;
    sbus.REQ_WDATA[i*DW +: DW]  = wdata;
    sbus.REQ[i]                 = 1'b1;
    e.idx   = i;
    e.wr    = wr;
    e.rdata = wr ? 8'h00 : ref_read(addr);
    if (wr) ref_write(addr, wdata);
    sb.push_back(e);
    t0      = cyc;
    ack_rel = -1;
    ack_v   = '0;
    rdata   = 8'h00;
    din_seq = '0;
    en_rel  = -1;
    en_kind = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rel = cyc - t0;
      if ((sbus.RD_EN || sbus.WR_EN) && en_rel < 0) begin
        en_rel  = rel;
        en_kind = {sbus.WR_EN, sbus.RD_EN};
      end
      if (rel >= 2 && rel <= 17) din_seq[17-rel] = sbus.DIN;
      if (sbus.ACK != '0) begin
        ack_rel     = rel;
        ack_v       = sbus.ACK;
        rdata       = sbus.RDATA;
        sbus.REQ[i] = 1'b0;
        break;
      end
    end
    if (ack_rel < 0) sbus.REQ[i] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (sbus.ACK   !== '0)   $display("FAIL reset_ack: got %b want 0", sbus.ACK);     else n_pass++;
    n_checks++; if (sbus.RDATA !== 8'h0) $display("FAIL reset_rdata: got %h want 00", sbus.RDATA); else n_pass++;
    n_checks++; if (sbus.BUSY  !== 1'b0) $display("FAIL reset_busy: got %b want 0", sbus.BUSY);   else n_pass++;
    n_checks++; if (sbus.RD_EN !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", sbus.RD_EN); else n_pass++;
    n_checks++; if (sbus.WR_EN !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", sbus.WR_EN); else n_pass++;
    n_checks++; if (sbus.DIN   !== 1'b0) $display("FAIL reset_din: got %b want 0", sbus.DIN);     else n_pass++;
  endtask

  task automatic test_single_write();
    int ack_rel, en_rel;
    logic [N_REQ-1:0] ack_v;
    logic [7:0] rdata;
    logic [15:0] din_seq;
    logic [1:0] en_kind;
    exp_t e;
    do_txn(0, 1'b1, 8'h34, 8'hA5, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (en_rel  !== 1)        $display("FAIL wr_en_cycle: got %0d want 1", en_rel);      else n_pass++;
    n_checks++; if (en_kind !== 2'b10)    $display("FAIL wr_en_kind: got %b want 10", en_kind);      else n_pass++;
    n_checks++; if (din_seq !== 16'h34A5) $display("FAIL wr_din_seq: got %h want 34a5", din_seq);    else n_pass++;
    n_checks++; if (ack_rel !== 18)       $display("FAIL wr_ack_cycle: got %0d want 18", ack_rel);   else n_pass++;
    n_checks++; if (ack_v !== onehot(e.idx)) $display("FAIL wr_ack: got %b want %b", ack_v, onehot(e.idx)); else n_pass++;
    n_checks++; if (rdata !== last_rdata) $display("FAIL wr_rdata_held: got %h want %h", rdata, last_rdata); else n_pass++;
  endtask

  task automatic test_read_back();
    int ack_rel, en_rel;
    logic [N_REQ-1:0] ack_v;
    logic [7:0] rdata;
    logic [15:0] din_seq;
    logic [1:0] en_kind;
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      do_txn(0, 1'b0, 8'h34, 8'h00, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
      e = sb.pop_front();
      exp_ptr = (e.idx + 1) % N_REQ;
      n_checks++; if (en_rel  !== 1)     $display("FAIL rd_en_cycle: got %0d want 1", en_rel);    else n_pass++;
      n_checks++; if (en_kind !== 2'b01) $display("FAIL rd_en_kind: got %b want 01", en_kind);    else n_pass++;
      n_checks++; if (ack_rel !== 18)    $display("FAIL rd_ack_cycle: got %0d want 18", ack_rel); else n_pass++;
      n_checks++; if (din_seq !== 16'h3400) $display("FAIL rd_din_seq: got %h want 3400", din_seq); else n_pass++;
      n_checks++; if (rdata !== e.rdata) $display("FAIL rd_data_%0d: got %h want %h", n, rdata, e.rdata); else n_pass++;
      last_rdata = e.rdata;
    end
    @(negedge clk);
    n_checks++; if (sbus.RDATA !== last_rdata) $display("FAIL rd_data_hold: got %h want %h", sbus.RDATA, last_rdata); else n_pass++;
  endtask

  task automatic test_read_only();
    int ack_rel, en_rel;
    logic [N_REQ-1:0] ack_v;
    logic [7:0] rdata;
    logic [15:0] din_seq;
    logic [1:0] en_kind;
    exp_t e;
    do_txn(0, 1'b0, RO_ADDR, 8'h00, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (rdata !== e.rdata) $display("FAIL ro_read: got %h want %h", rdata, e.rdata); else n_pass++;
    last_rdata = e.rdata;
    do_txn(0, 1'b1, RO_ADDR, 8'hFF, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (ack_v !== onehot(e.idx)) $display("FAIL ro_write_ack: got %b want %b", ack_v, onehot(e.idx)); else n_pass++;
    do_txn(0, 1'b0, RO_ADDR, 8'h00, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (rdata !== e.rdata) $display("FAIL ro_read_after_write: got %h want %h", rdata, e.rdata); else n_pass++;
    last_rdata = e.rdata;
  endtask

  task automatic test_second_requester();
    int ack_rel, en_rel;
    logic [N_REQ-1:0] ack_v;
    logic [7:0] rdata;
    logic [15:0] din_seq;
    logic [1:0] en_kind;
    exp_t e;
    do_txn(1, 1'b1, 8'h78, 8'h5C, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (din_seq !== 16'h785C) $display("FAIL req1_din_seq: got %h want 785c", din_seq); else n_pass++;
    n_checks++; if (ack_v !== onehot(e.idx)) $display("FAIL req1_write_ack: got %b want %b", ack_v, onehot(e.idx)); else n_pass++;
    do_txn(1, 1'b0, 8'h78, 8'h00, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (ack_v !== onehot(e.idx)) $display("FAIL req1_read_ack: got %b want %b", ack_v, onehot(e.idx)); else n_pass++;
    n_checks++; if (rdata !== e.rdata) $display("FAIL req1_read: got %h want %h", rdata, e.rdata); else n_pass++;
    last_rdata = e.rdata;
  endtask

  task automatic test_unmapped();
    int ack_rel, en_rel;
    logic [N_REQ-1:0] ack_v;
    logic [7:0] rdata;
    logic [15:0] din_seq;
    logic [1:0] en_kind;
    exp_t e;
    do_txn(0, 1'b0, 8'h00, 8'h00, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (ack_rel !== 18)    $display("FAIL unmapped_ack_cycle: got %0d want 18", ack_rel); else n_pass++;
    n_checks++; if (rdata !== e.rdata) $display("FAIL unmapped_read: got %h want %h", rdata, e.rdata); else n_pass++;
    last_rdata = e.rdata;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   g, n_ack, n_en, last_ack;
    @(negedge clk);
    sbus.REQ_WR[0]         = 1'b1;
    sbus.REQ_ADDR[0 +: AW] = 8'hA1;
    sbus.REQ_WDATA[0 +: DW] = 8'hC3;
    sbus.REQ_WR[1]          = 1'b0;
    sbus.REQ_ADDR[AW +: AW] = 8'hA1;
    sbus.REQ_WDATA[DW +: DW] = 8'h00;
    g = exp_ptr;
    for (int t = 0; t < 4; t++) begin
      e.idx   = g;
      e.wr    = (g == 0);
      e.rdata = (g == 0) ? 8'h00 : ref_read(8'hA1);
      if (g == 0) ref_write(8'hA1, 8'hC3);
      sb.push_back(e);
      g = (g + 1) % N_REQ;
    end
    sbus.REQ = '1;
    last_ack = cyc;
    n_ack    = 0;
    n_en     = 0;
    for (int k = 0; k < 4 * FRAME_CYCLES + 20; k++) begin
      @(negedge clk);
      if (sbus.RD_EN || sbus.WR_EN) n_en++;
      if (sbus.ACK != '0) begin
        e = sb.pop_front();
        exp_ptr = (e.idx + 1) % N_REQ;
        n_checks++; if (sbus.ACK !== onehot(e.idx)) $display("FAIL b2b_grant_%0d: got %b want %b", n_ack, sbus.ACK, onehot(e.idx)); else n_pass++;
        if (!e.wr) begin
          n_checks++; if (sbus.RDATA !== e.rdata) $display("FAIL b2b_rdata_%0d: got %h want %h", n_ack, sbus.RDATA, e.rdata); else n_pass++;
        end
        n_checks++;
        if ((cyc - last_ack) !== ((n_ack == 0) ? 18 : FRAME_CYCLES))
          $display("FAIL b2b_ack_spacing_%0d: got %0d want %0d", n_ack, cyc - last_ack, (n_ack == 0) ? 18 : FRAME_CYCLES);
        else n_pass++;
        last_ack = cyc;
        n_ack++;
        if (n_ack == 4) begin
          sbus.REQ = '0;
          break;
        end
      end
    end
    sbus.REQ = '0;
    n_checks++; if (n_ack !== 4)         $display("FAIL b2b_ack_count: got %0d want 4", n_ack);          else n_pass++;
    n_checks++; if (n_en !== 4)          $display("FAIL b2b_enable_count: got %0d want 4", n_en);        else n_pass++;
    n_checks++; if (rf_violations !== 0) $display("FAIL b2b_mid_frame_enable: got %0d want 0", rf_violations); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int   t0, n_ack, ack_rel, en_rel;
    logic busy_before;
    logic [N_REQ-1:0] ack_v;
    logic [7:0] rdata;
    logic [15:0] din_seq;
    logic [1:0] en_kind;
    exp_t e;
    @(negedge clk);
    sbus.REQ_WR[0]          = 1'b1;
    sbus.REQ_ADDR[0 +: AW]  = 8'h34;
    sbus.REQ_WDATA[0 +: DW] = 8'h77;
    sbus.REQ[0]             = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cyc - t0 == 12) break;
    end
    busy_before = sbus.BUSY;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_before !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy_before); else n_pass++;
    n_checks++; if (sbus.BUSY  !== 1'b0)  $display("FAIL abort_busy: got %b want 0", sbus.BUSY);    else n_pass++;
    n_checks++; if (sbus.RDATA !== 8'h0)  $display("FAIL abort_rdata: got %h want 00", sbus.RDATA); else n_pass++;
    n_checks++; if (sbus.DIN   !== 1'b0)  $display("FAIL abort_din: got %b want 0", sbus.DIN);      else n_pass++;
    n_checks++; if ({sbus.RD_EN, sbus.WR_EN} !== 2'b00) $display("FAIL abort_enables: got %b want 00", {sbus.RD_EN, sbus.WR_EN}); else n_pass++;
    sbus.REQ = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_reset();
    sb.delete();
    exp_ptr    = 0;
    last_rdata = 8'h00;
    n_ack = 0;
    repeat (25) begin
      @(negedge clk);
      if (sbus.ACK != '0) n_ack++;
    end
    n_checks++; if (n_ack !== 0) $display("FAIL abort_no_ack: got %0d want 0", n_ack); else n_pass++;
    do_txn(0, 1'b0, 8'h34, 8'h00, ack_rel, ack_v, rdata, din_seq, en_rel, en_kind);
    e = sb.pop_front();
    exp_ptr = (e.idx + 1) % N_REQ;
    n_checks++; if (ack_rel !== 18)    $display("FAIL abort_readback_ack: got %0d want 18", ack_rel); else n_pass++;
    n_checks++; if (rdata !== e.rdata) $display("FAIL abort_readback: got %h want %h", rdata, e.rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_read_only();
    test_second_requester();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
